// File: rtl/popcount_accum.sv
// popcount_accum: sums lane popcounts over BEATS words, holds result until taken; POPCOUNT_APPROX_EN prunes MSB lanes
module popcount_accum #(
  parameter int N = 8,
  parameter int BEATS = 4,
  parameter int THRESH = 10,
  parameter int APPROX_LANES = 1,
  localparam int CW = $clog2(N * BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_sum,
  output logic          out_fire
);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
`ifdef POPCOUNT_APPROX_EN
  localparam int LANES = N - APPROX_LANES;
`else
  localparam int LANES = N + 0 * APPROX_LANES;
`endif
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t r_state, w_next;
  logic r_up, r_fire, w_take, w_give, w_last;
  logic [BW-1:0] r_cnt;
  logic [CW-1:0] r_acc, w_pc, w_sum;
  assign in_ready = r_up && r_state == ACCUM;
  assign out_valid = r_state == HOLD;
  assign out_sum = r_acc;
  assign out_fire = r_fire;
  assign w_take = in_valid && in_ready;
  assign w_give = out_valid && out_ready;
  assign w_last = r_cnt == BW'(BEATS - 1);
  assign w_sum = r_acc + w_pc;
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < LANES; i++) w_pc = w_pc + CW'(in_data[i]);
  end
  always_comb begin
    w_next = r_state;
    if (clear) w_next = ACCUM;
    else if (r_state == ACCUM) w_next = w_take && w_last ? HOLD : ACCUM;
    else w_next = out_ready ? ACCUM : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ACCUM;
    else r_state <= w_next;
  // the accumulator doubles as the held result, so zeroing it also clears out_sum
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_up <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_fire <= 1'b0;
    end else begin
      r_up <= 1'b1;
      if (clear || w_give) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_fire <= 1'b0;
      end else if (w_take) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        r_acc <= w_sum;
        r_fire <= int'(w_sum) >= THRESH;
      end
    end
endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum: directed and random checks of popcount_accum against a queue-based model
module tb_popcount_accum;
  localparam int N = 8, BEATS = 4, THRESH = 10, CW = $clog2(N * BEATS + 1);
`ifdef POPCOUNT_APPROX_EN
  localparam logic [N-1:0] MASK = 8'h7F;
`else
  localparam logic [N-1:0] MASK = 8'hFF;
`endif
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [N-1:0] in_data = '0;
  logic in_ready, out_valid, out_fire;
  logic [CW-1:0] out_sum;
  int n_tests = 0, n_fail = 0, n_res = 0;
  int q_words[$];
  int exp_q[$];
  bit up = 0;
  popcount_accum dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_fire(out_fire)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // reference: words accepted while idle are grouped into BEATS, one pending result at a time
  always @(negedge clk) begin
    int s;
    bit take, give;
    if (!rst_n) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_fire", out_fire, 0);
      q_words.delete();
      exp_q.delete();
      up = 0;
    end else begin
      chk("valid", out_valid, exp_q.size() != 0);
      chk("ready", in_ready, up && exp_q.size() == 0);
      if (exp_q.size() != 0) begin
        chk("sum", out_sum, exp_q[0]);
        chk("fire", out_fire, exp_q[0] >= THRESH);
      end
      take = in_valid && up && exp_q.size() == 0;
      give = out_ready && exp_q.size() != 0;
      if (clear) begin
        q_words.delete();
        exp_q.delete();
      end else begin
        if (give) begin
          void'(exp_q.pop_front());
          n_res++;
        end
        if (take) begin
          q_words.push_back(int'(in_data & MASK));
          if (q_words.size() == BEATS) begin
            s = 0;
            foreach (q_words[k]) s += $countones(q_words[k]);
            exp_q.push_back(s);
            q_words.delete();
          end
        end
      end
      up = 1;
    end
  end
  task automatic beat(input logic [N-1:0] w);
    bit t;
    int k = 0;
    in_valid = 1;
    in_data = w;
    do begin
      @(negedge clk) t = in_ready;
      @(posedge clk) #1;
      k++;
    end while (!t && k < 50);
    if (!t) chk("beat_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic wait_res(input string tag, input int sum, input bit fire, input int max);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < max) begin
      k++;
      @(negedge clk);
    end
    chk({tag, "_seen"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, sum);
    chk({tag, "_fire"}, out_fire, fire);
  endtask
  initial begin
    int cyc, base;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    beat(8'hFF); beat(8'h0F); beat(8'h00); beat(8'h01);
    wait_res("t32", 13, 1, 0);
    @(posedge clk) #1;
    out_ready = 0;
    repeat (4) beat(8'h03);
    wait_res("t33", 8, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t33_hold_valid", out_valid, 1);
      chk("t33_hold_ready", in_ready, 0);
      chk("t33_hold_sum", out_sum, 8);
      chk("t33_hold_fire", out_fire, 0);
    end
    @(posedge clk) #1 out_ready = 1;
    @(posedge clk) #1;
    beat(8'hFF); beat(8'hFF);
    clear = 1; in_valid = 1; in_data = 8'hFF;
    @(posedge clk) #1 clear = 0; in_valid = 0;
    repeat (4) beat(8'h01);
    wait_res("t34", 4, 0, 0);
    @(posedge clk) #1;
    beat(8'h80); beat(8'h80);
    in_valid = 1; in_data = 8'h80;
    #2 rst_n = 0;
    #1;
    chk("t35_async_valid", out_valid, 0);
    chk("t35_async_ready", in_ready, 0);
    chk("t35_async_sum", out_sum, 0);
    chk("t35_async_fire", out_fire, 0);
    in_valid = 0;
    @(negedge clk);
    @(posedge clk) #1 rst_n = 1;
    repeat (4) beat(8'h80);
`ifdef POPCOUNT_APPROX_EN
    wait_res("t35", 0, 0, 0);
`else
    wait_res("t35", 4, 0, 0);
`endif
    @(posedge clk) #1;
    beat(8'h80); beat(8'h80); beat(8'hFF); beat(8'hFF);
`ifdef POPCOUNT_APPROX_EN
    wait_res("t36", 14, 1, 0);
`else
    wait_res("t36", 18, 1, 0);
`endif
    base = n_res;
    cyc = 0;
    while (n_res - base < 1000 && cyc < 40000) begin
      @(posedge clk) #1;
      in_valid = 1'($urandom);
      in_data = N'($urandom);
      out_ready = 1'($urandom);
      cyc++;
    end
    in_valid = 0;
    chk("t37_results", n_res - base >= 1000, 1);
    @(posedge clk) #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
- REQ-001: Parameter N, default 8, input word width (lanes), legal range 2..64.
- REQ-002: Parameter BEATS, default 4, words accumulated per result, legal range 1..256.
- REQ-003: Parameter THRESH, default 10, activation threshold compared against the accumulated sum.
- REQ-004: Parameter APPROX_LANES, default 1, number of MSB lanes pruned when approximation is compiled in; legal range 0..N-1.
- REQ-005: Localparam CW = $clog2(N*BEATS+1), the sum width.
- REQ-006: clk  input  1  single clock; all state updates on its rising edge.
- REQ-007: rst_n  input  1  reset, asynchronous, active-low.
- REQ-008: clear  input  1  synchronous abort of the current accumulation.
- REQ-009: in_valid  input  1  in_data is valid.
- REQ-010: in_ready  output  1  block accepts a word this cycle.
- REQ-011: in_data  input  N  input word, one bit per lane.
- REQ-012: out_valid  output  1  result is valid.
- REQ-013: out_ready  input  1  consumer accepts the result.
- REQ-014: out_sum  output  CW  accumulated popcount of BEATS words.
- REQ-015: out_fire  output  1  out_sum >= THRESH.

Function
- REQ-016: An input beat SHALL be accepted only in a cycle where in_valid && in_ready.
- REQ-017: The per-word count SHALL be the exact number of 1 bits in in_data, zero-extended to CW bits (no overflow possible).
- REQ-018: The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
- REQ-019: In ACCUM, each accepted beat SHALL add its count to the accumulator and increment the beat counter.
- REQ-020: On the accepted beat where the counter equals BEATS-1, the FSM SHALL go to HOLD; out_sum SHALL equal the total including that beat; out_valid SHALL rise the next cycle (latency 1 cycle from the final beat).
- REQ-021: In HOLD, out_sum and out_fire SHALL be stable until out_valid && out_ready.
- REQ-022: On the output handshake, the FSM SHALL return to ACCUM with the accumulator and counter zeroed; in_ready SHALL be 1 the following cycle (no same-cycle bypass).
- REQ-023: out_fire SHALL be a registered compare, updated together with out_sum.
- REQ-024: BEATS=1: every accepted word SHALL produce a result one cycle later.
- REQ-025: clear=1 SHALL zero the accumulator, counter, out_sum and out_fire, drop out_valid and enter ACCUM next cycle; any beat presented with clear is discarded.
- REQ-026: clear SHALL take priority over simultaneous input and output handshakes.
- REQ-027: in_data SHALL be ignored when in_valid=0 or in HOLD.

Reset
- REQ-028: While rst_n=0: state=ACCUM, accumulator=0, counter=0, out_valid=0, out_sum=0, out_fire=0, in_ready=0.
- REQ-029: in_ready SHALL become 1 on the first clk edge after rst_n deasserts; reset mid-accumulation discards the partial sum.

Configuration
- REQ-030: Macro POPCOUNT_APPROX_EN, when defined: the per-word count SHALL ignore lanes N-1 down to N-APPROX_LANES (counted as 0); CW is unchanged.
- REQ-031: Without POPCOUNT_APPROX_EN: the per-word count SHALL be exact over all N lanes.

Verification (N=8, BEATS=4, THRESH=10)
- REQ-032: Beats 0xFF,0x0F,0x00,0x01 back-to-back, out_ready=1 -> out_sum=13, out_fire=1, out_valid for 1 cycle, 1 cycle after beat 4.
- REQ-033: Beats 0x03,0x03,0x03,0x03, out_ready=0 for 5 cycles -> out_sum=8, out_fire=0 held stable; in_ready=0 throughout HOLD.
- REQ-034: clear asserted after 2 beats of 0xFF, then beats 0x01 x4 -> out_sum=4, no result from the aborted run.
- REQ-035: rst_n pulsed low asynchronously mid-word-3 -> all outputs 0 immediately; next 4 beats of 0x80 -> out_sum=4.
- REQ-036: POPCOUNT_APPROX_EN, APPROX_LANES=1, beats 0x80,0x80,0xFF,0xFF -> out_sum=14; without macro -> 18.
- REQ-037: Random in_valid/out_ready with 50% duty, 1000 results -> every out_sum matches the reference model; no beat lost or duplicated.
